// File: rtl/dlf_pi_decim.sv
// Decimating PI loop filter for the digital PLL: removes the TDC mid-scale offset, integrates-and-dumps
// 2**DEC_LOG2 samples, subtracts NC and runs a saturating PI. Optional sat counter: `define DLF_SAT_CNT_EN.
module dlf_pi_decim #(
    parameter int TDC_W    = 5,
    parameter int DEC_LOG2 = 5,
    parameter int NC_W     = 15,
    parameter int COEF_W   = 16,
    parameter int FRAC     = 12,
    parameter int OUT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     clear,
    input  logic                     tdc_valid,
    input  logic [TDC_W-1:0]         tdc_dout,
    input  logic [NC_W-1:0]          nc_in,
    input  logic signed [COEF_W-1:0] kp,
    input  logic signed [COEF_W-1:0] ki,
    output logic signed [OUT_W-1:0]  err_out,
    output logic signed [OUT_W-1:0]  dlf_out,
    output logic                     out_valid,
`ifdef DLF_SAT_CNT_EN
    output logic [7:0]               sat_cnt,
`endif
    output logic                     busy
);

    localparam int AW = TDC_W + DEC_LOG2 + 1;
    localparam int SW = TDC_W + 1;
    localparam int PW = COEF_W + OUT_W;
    localparam int WW = 64;
    localparam logic signed [WW-1:0] SMAX = (64'sd1 <<< (OUT_W - 1)) - 64'sd1;
    localparam logic signed [WW-1:0] SMIN = -(64'sd1 <<< (OUT_W - 1));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        FILT = 2'd2,
        UPD  = 2'd3
    } state_t;

    function automatic logic signed [OUT_W-1:0] sat_f(input logic signed [WW-1:0] v);
        if (v > SMAX) begin
            sat_f = SMAX[OUT_W-1:0];
        end else if (v < SMIN) begin
            sat_f = SMIN[OUT_W-1:0];
        end else begin
            sat_f = v[OUT_W-1:0];
        end
    endfunction

    function automatic logic clip_f(input logic signed [WW-1:0] v);
        clip_f = (v > SMAX) || (v < SMIN);
    endfunction

    state_t                     state_q, state_d;
    logic signed [AW-1:0]       acc_q, acc_d;
    logic [DEC_LOG2-1:0]        cnt_q, cnt_d;
    logic signed [OUT_W-1:0]    err_q, err_d;
    logic signed [PW-1:0]       pi_q, pi_d, ii_q, ii_d;
    logic signed [OUT_W-1:0]    integ_q, integ_d;
    logic signed [OUT_W-1:0]    dlf_q, dlf_d;
    logic signed [OUT_W-1:0]    err_out_q, err_out_d;
    logic                       valid_q, valid_d;
    logic [7:0]                 sat_cnt_q, sat_cnt_d;

    logic                       samp_en_s, dump_s, filt_s, upd_s;
    logic signed [SW-1:0]       samp_s;
    logic signed [AW-1:0]       acc_sum_s;
    logic signed [OUT_W-1:0]    dec_s;
    logic signed [WW-1:0]       err_wide_s, integ_sum_s, out_sum_s;
    logic signed [PW-1:0]       kp_prod_s, ki_prod_s;

    assign samp_s     = $signed({1'b0, tdc_dout}) - $signed({2'b01, {(TDC_W-1){1'b0}}});
    assign acc_sum_s  = acc_q + AW'(samp_s);
    assign dec_s      = sat_f(WW'(acc_sum_s));
    assign err_wide_s = WW'(dec_s) - $signed(WW'({1'b0, nc_in}));
    assign kp_prod_s  = PW'(kp) * PW'(err_q);
    assign ki_prod_s  = PW'(ki) * PW'(err_q);
    assign integ_sum_s = WW'(integ_q) + WW'(ii_q);
    assign out_sum_s   = integ_sum_s + WW'(pi_q);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; dropping enable returns to IDLE from anywhere
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = ACC;
                ACC:     state_d = dump_s ? FILT : ACC;
                FILT:    state_d = UPD;
                UPD:     state_d = ACC;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM strobes; sampling continues through FILT/UPD so no sample is lost
    always_comb begin
        samp_en_s = 1'b0;
        dump_s    = 1'b0;
        filt_s    = 1'b0;
        upd_s     = 1'b0;
        if (enable && (state_q != IDLE)) begin
            samp_en_s = tdc_valid;
            dump_s    = tdc_valid && (state_q == ACC) && (cnt_q == {DEC_LOG2{1'b1}});
            filt_s    = (state_q == FILT);
            upd_s     = (state_q == UPD);
        end else begin
            samp_en_s = 1'b0;
        end
    end

    // Datapath next-state: accumulator, decimated error, PI products, outputs
    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        pi_d      = pi_q;
        ii_d      = ii_q;
        integ_d   = integ_q;
        dlf_d     = dlf_q;
        err_out_d = err_out_q;
        valid_d   = upd_s;
        sat_cnt_d = sat_cnt_q;

        if (!enable || (state_q == IDLE) || dump_s) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (samp_en_s) begin
            acc_d = acc_sum_s;
            cnt_d = cnt_q + DEC_LOG2'(1);
        end else begin
            acc_d = acc_q;
        end

        if (dump_s) begin
            err_d = sat_f(err_wide_s);
        end else begin
            err_d = err_q;
        end

        if (filt_s) begin
            pi_d = kp_prod_s >>> FRAC;
            ii_d = ki_prod_s >>> FRAC;
        end else begin
            pi_d = pi_q;
        end

        if (upd_s) begin
            err_out_d = err_q;
        end else begin
            err_out_d = err_out_q;
        end

        // clear beats a coincident update, which still signals valid with a zero output
        if (clear) begin
            integ_d   = '0;
            dlf_d     = '0;
            sat_cnt_d = 8'd0;
        end else if (upd_s) begin
            integ_d = sat_f(integ_sum_s);
            dlf_d   = sat_f(out_sum_s);
            if ((clip_f(integ_sum_s) || clip_f(out_sum_s)) && (sat_cnt_q != 8'hFF)) begin
                sat_cnt_d = sat_cnt_q + 8'd1;
            end else begin
                sat_cnt_d = sat_cnt_q;
            end
        end else begin
            integ_d = integ_q;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            err_q     <= '0;
            pi_q      <= '0;
            ii_q      <= '0;
            integ_q   <= '0;
            dlf_q     <= '0;
            err_out_q <= '0;
            valid_q   <= 1'b0;
            sat_cnt_q <= 8'd0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            pi_q      <= pi_d;
            ii_q      <= ii_d;
            integ_q   <= integ_d;
            dlf_q     <= dlf_d;
            err_out_q <= err_out_d;
            valid_q   <= valid_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign err_out   = err_out_q;
    assign dlf_out   = dlf_q;
    assign out_valid = valid_q;
    assign busy      = (state_q != IDLE);
`ifdef DLF_SAT_CNT_EN
    assign sat_cnt   = sat_cnt_q;
`else
    logic unused_sat_s;
    assign unused_sat_s = ^sat_cnt_q;
`endif

endmodule

// File: tb/tb_dlf_pi_decim.sv
// Directed self-checking bench for dlf_pi_decim at default parameters (32-sample windows, FRAC=12).
module tb_dlf_pi_decim;

    logic               clk = 1'b0;
    logic               rst, enable, clear, tdc_valid;
    logic [4:0]         tdc_dout;
    logic [14:0]        nc_in;
    logic signed [15:0] kp, ki;
    logic signed [15:0] err_out, dlf_out;
    logic               out_valid, busy;
`ifdef DLF_SAT_CNT_EN
    logic [7:0]         sat_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int vcnt  = 0;
    int vbase;
    longint exp_integ;
    int exp_sat;

    dlf_pi_decim dut (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear),
        .tdc_valid(tdc_valid), .tdc_dout(tdc_dout), .nc_in(nc_in),
        .kp(kp), .ki(ki), .err_out(err_out), .dlf_out(dlf_out),
        .out_valid(out_valid),
`ifdef DLF_SAT_CNT_EN
        .sat_cnt(sat_cnt),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    // counts every out_valid pulse, settled well before the next negedge
    always @(posedge clk) begin
        #2;
        if (out_valid === 1'b1) vcnt = vcnt + 1;
    end

    task automatic check_eq(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic feed(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            if (i > 0) repeat (gap) tick();
            tdc_valid = 1'b1;
            tick();
            tdc_valid = 1'b0;
        end
    endtask

    task automatic win(input string tag, input int gap, input longint e_err, input longint e_dlf);
        feed(32, gap);
        tick();
        check_eq({tag, "_early"}, out_valid, 0);
        tick();
        check_eq({tag, "_ov"}, out_valid, 1);
        check_eq({tag, "_err"}, err_out, e_err);
        check_eq({tag, "_dlf"}, dlf_out, e_dlf);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; clear = 1'b0; tdc_valid = 1'b0;
        tdc_dout = 5'd16; nc_in = 15'd0; kp = 16'sd4096; ki = 16'sd4096;
        tick(); tick();
        check_eq("rst_err", err_out, 0);
        check_eq("rst_dlf", dlf_out, 0);
        check_eq("rst_ov", out_valid, 0);
        check_eq("rst_busy", busy, 0);
        rst = 1'b0;
        tick();

        // mid-scale input, nc=0: zero error and output
        enable = 1'b1;
        tick();
        check_eq("busy_on", busy, 1);
        win("mid", 0, 0, 0);
        tick();
        check_eq("ov_pulse", out_valid, 0);

        // error 32-20=12 with unity ki ramps the integrator
        tdc_dout = 5'd17; nc_in = 15'd20; kp = 16'sd0;
        win("ramp1", 0, 12, 12);
        win("ramp2", 0, 12, 24);
        win("ramp3", 0, 12, 36);

        // error 480, ki=32767 -> ii=(32767*480)>>>12=3839 per update, until clamp
        tdc_dout = 5'd31; nc_in = 15'd0; ki = 16'sd32767;
        exp_integ = 36; exp_sat = 0;
        for (int k = 0; k < 10; k++) begin
            exp_integ = exp_integ + 3839;
            if (exp_integ > 32767) begin
                exp_integ = 32767;
                exp_sat = exp_sat + 1;
            end
            win("clamp", 0, 480, exp_integ);
        end
        check_eq("clamp_final", dlf_out, 32767);
`ifdef DLF_SAT_CNT_EN
        check_eq("sat_cnt", sat_cnt, exp_sat);
`endif

        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_eq("clear_dlf", dlf_out, 0);
`ifdef DLF_SAT_CNT_EN
        check_eq("clear_sat", sat_cnt, 0);
`endif

        // enable dropped after 20 samples: partial window discarded
        tdc_dout = 5'd17; nc_in = 15'd20; kp = 16'sd0; ki = 16'sd4096;
        vbase = vcnt;
        feed(20, 0);
        enable = 1'b0;
        tick(); tick();
        check_eq("drop_busy", busy, 0);
        check_eq("drop_dlf", dlf_out, 0);
        enable = 1'b1;
        tick();
        feed(31, 0);
        tick(); tick(); tick();
        check_eq("drop_noov", vcnt - vbase, 0);
        feed(1, 0);
        tick(); tick();
        check_eq("drop_ov", out_valid, 1);
        check_eq("drop_cnt", vcnt - vbase, 1);
        check_eq("drop_err", err_out, 12);
        check_eq("drop_dlf2", dlf_out, 12);

        // sparse valid (1 of 3), nc=5 at mid-scale -> err -5, gains zero hold dlf
        tdc_dout = 5'd16; nc_in = 15'd5; ki = 16'sd0;
        vbase = vcnt;
        win("sparse", 2, -5, 12);
        check_eq("sparse_cnt", vcnt - vbase, 1);

        // asynchronous reset while FILT is in flight
        tdc_dout = 5'd17; nc_in = 15'd20; ki = 16'sd4096;
        vbase = vcnt;
        feed(32, 0);
        rst = 1'b1;
        #1;
        check_eq("mrst_err", err_out, 0);
        check_eq("mrst_dlf", dlf_out, 0);
        check_eq("mrst_busy", busy, 0);
        tick();
        rst = 1'b0;
        tick();
        feed(31, 0);
        tick(); tick(); tick();
        check_eq("mrst_noov", vcnt - vbase, 0);
        feed(1, 0);
        tick(); tick();
        check_eq("mrst_ov", out_valid, 1);
        check_eq("mrst_err2", err_out, 12);
        check_eq("mrst_dlf2", dlf_out, 12);

        // clear coinciding with UPD: valid still pulses, output forced to zero
        feed(32, 0);
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_eq("clrupd_ov", out_valid, 1);
        check_eq("clrupd_dlf", dlf_out, 0);
        check_eq("clrupd_err", err_out, 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
